fifo_wm: RTL and testbench

//  Parametrised valid/ready FIFO. Adds a fill-level output, almost-full/almost-empty

---
 rtl/fifo_wm.sv | 106 ++++++++++
 tb/tb_fifo_wm.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wm.sv
// fifo_wm: valid/ready FIFO with a fill-level output, almost-full/almost-empty
// watermarks, a synchronous flush and an optional same-cycle empty bypass.
//
// Handshake: a word moves on a rising edge where valid and ready are both high.
// The sender holds data and valid until the transfer, and valid never depends
// on ready. data_in_ready_o may depend on data_out_ready_i: a full FIFO that is
// popped in the same cycle still accepts a word.
module fifo_wm #(
  parameter int Datawidth   = 16,
  parameter int Depth       = 8,
  parameter int AlmostFull  = 6,
  parameter int AlmostEmpty = 2,
  parameter int Bypass      = 1
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic                         flush_i,
  input  logic [Datawidth-1:0]         data_in_i,
  input  logic                         data_in_valid_i,
  output logic                         data_in_ready_o,
  output logic [Datawidth-1:0]         data_out_o,
  output logic                         data_out_valid_o,
  input  logic                         data_out_ready_i,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         almost_full_o,
  output logic                         almost_empty_o
);

  localparam int AW = $clog2(Depth);
  localparam int CW = $clog2(Depth + 1);
  localparam bit BypassEn = (Bypass != 0);
  localparam logic [AW:0]   PtrOne  = (AW + 1)'(1);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [CW-1:0] AfLevel = CW'(AlmostFull);
  localparam logic [CW-1:0] AeLevel = CW'(AlmostEmpty);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // without a separate flag.
  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [Datawidth-1:0] mem_q [Depth];

  logic full, empty, blocked;
  logic push, pop, bypass_hit, wr_en, rd_en;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  // Reset and flush both hide the FIFO from its neighbours so nothing transfers.
  assign blocked = srst_i | flush_i;

  assign data_in_ready_o  = ~blocked & (~full | data_out_ready_i);
  assign data_out_valid_o = ~blocked & (~empty | (BypassEn & data_in_valid_i));
  assign data_out_o       = (BypassEn && empty) ? data_in_i
                                                : mem_q[rd_ptr_q[AW-1:0]];

  assign push       = data_in_valid_i & data_in_ready_o;
  assign pop        = data_out_valid_o & data_out_ready_i;
  // A word that goes straight through an empty FIFO never touches storage.
  assign bypass_hit = BypassEn & empty & push & pop;
  assign wr_en      = push & ~bypass_hit;
  assign rd_en      = pop & ~bypass_hit;

  assign count_o        = count_q;
  assign almost_full_o  = (count_q >= AfLevel);
  assign almost_empty_o = (count_q <= AeLevel);

  // Next-state for pointers and fill level; flush clears everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrOne;
    if (rd_en) rd_ptr_d = rd_ptr_q + PtrOne;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control state registers; reset wins over flush.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_in_i;
  end

endmodule

// File: tb/tb_fifo_wm.sv
// Testbench for fifo_wm. dut0 is built without bypass, dut1 with bypass.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_fifo_wm;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst  [2];
  logic          flush [2];
  logic          vin   [2];
  logic          ordy  [2];
  logic          irdy  [2];
  logic          vout  [2];
  logic          af    [2];
  logic          ae    [2];
  logic [DW-1:0] din   [2];
  logic [DW-1:0] dout  [2];
  logic [3:0]    cnt   [2];

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  // Watermark expectations indexed by fill level 0..8 (AlmostFull=6, AlmostEmpty=2).
  logic af_tab [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
  logic ae_tab [9] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
  int   duty_tab [5] = '{10, 30, 50, 70, 90};

  fifo_wm #(.Datawidth(16), .Depth(8), .AlmostFull(6), .AlmostEmpty(2), .Bypass(0)) dut0 (
    .clk_i(clk), .srst_i(srst[0]), .flush_i(flush[0]),
    .data_in_i(din[0]), .data_in_valid_i(vin[0]), .data_in_ready_o(irdy[0]),
    .data_out_o(dout[0]), .data_out_valid_o(vout[0]), .data_out_ready_i(ordy[0]),
    .count_o(cnt[0]), .almost_full_o(af[0]), .almost_empty_o(ae[0])
  );

  fifo_wm #(.Datawidth(16), .Depth(8), .AlmostFull(6), .AlmostEmpty(2), .Bypass(1)) dut1 (
    .clk_i(clk), .srst_i(srst[1]), .flush_i(flush[1]),
    .data_in_i(din[1]), .data_in_valid_i(vin[1]), .data_in_ready_o(irdy[1]),
    .data_out_o(dout[1]), .data_out_valid_o(vout[1]), .data_out_ready_i(ordy[1]),
    .count_o(cnt[1]), .almost_full_o(af[1]), .almost_empty_o(ae[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset(input int s);
    srst[s] = 1'b1; vin[s] = 1'b1; ordy[s] = 1'b1; din[s] = 16'h5555;
    step(); step();
    @(negedge clk);
    n_checks++; if (irdy[s] !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready dut%0d: got %b want 0", s, irdy[s]); end
    n_checks++; if (vout[s] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid dut%0d: got %b want 0", s, vout[s]); end
    step();
    srst[s] = 1'b0; vin[s] = 1'b0; ordy[s] = 1'b0;
    @(negedge clk);
    n_checks++; if (cnt[s] !== 4'd0) begin n_fail++; $display("FAIL reset_count dut%0d: got %0d want 0", s, cnt[s]); end
    n_checks++; if (ae[s] !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty dut%0d: got %b want 1", s, ae[s]); end
    n_checks++; if (af[s] !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full dut%0d: got %b want 0", s, af[s]); end
    n_checks++; if (irdy[s] !== 1'b1) begin n_fail++; $display("FAIL release_in_ready dut%0d: got %b want 1", s, irdy[s]); end
    n_checks++; if (vout[s] !== 1'b0) begin n_fail++; $display("FAIL release_out_valid dut%0d: got %b want 0", s, vout[s]); end
    step();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      din[0] = 16'(i); vin[0] = 1'b1; ordy[0] = 1'b0;
      @(negedge clk);
      n_checks++; if (irdy[0] !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready push %0d: got %b want 1", i, irdy[0]); end
      n_checks++; if (cnt[0] !== 4'(i - 1)) begin n_fail++; $display("FAIL fill_count push %0d: got %0d want %0d", i, cnt[0], i - 1); end
      step();
    end
    vin[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (irdy[0] !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", irdy[0]); end
    n_checks++; if (cnt[0] !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d want 8", cnt[0]); end
    step();
    ordy[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_checks++; if (vout[0] !== 1'b1) begin n_fail++; $display("FAIL drain_valid word %0d: got %b want 1", i, vout[0]); end
      n_checks++; if (dout[0] !== 16'(i)) begin n_fail++; $display("FAIL drain_data word %0d: got %h want %h", i, dout[0], 16'(i)); end
      step();
    end
    ordy[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (vout[0] !== 1'b0) begin n_fail++; $display("FAIL drained_valid: got %b want 0", vout[0]); end
    n_checks++; if (cnt[0] !== 4'd0) begin n_fail++; $display("FAIL drained_count: got %0d want 0", cnt[0]); end
    step();
  endtask

  task automatic test_latency();
    vin[0] = 1'b1; din[0] = 16'h1234; ordy[0] = 1'b1;
    @(negedge clk);
    n_checks++; if (vout[0] !== 1'b0) begin n_fail++; $display("FAIL nobypass_same_cycle_valid: got %b want 0", vout[0]); end
    step();
    vin[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (vout[0] !== 1'b1) begin n_fail++; $display("FAIL nobypass_next_valid: got %b want 1", vout[0]); end
    n_checks++; if (dout[0] !== 16'h1234) begin n_fail++; $display("FAIL nobypass_next_data: got %h want 1234", dout[0]); end
    n_checks++; if (cnt[0] !== 4'd1) begin n_fail++; $display("FAIL nobypass_count: got %0d want 1", cnt[0]); end
    step();
    ordy[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (cnt[0] !== 4'd0) begin n_fail++; $display("FAIL nobypass_after_pop_count: got %0d want 0", cnt[0]); end
    step();
  endtask

  task automatic test_watermarks();
    ordy[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      vin[0] = 1'b1; din[0] = 16'h0100 + 16'(k);
      @(negedge clk);
      n_checks++; if (af[0] !== af_tab[k]) begin n_fail++; $display("FAIL wm_fill_af count %0d: got %b want %b", k, af[0], af_tab[k]); end
      n_checks++; if (ae[0] !== ae_tab[k]) begin n_fail++; $display("FAIL wm_fill_ae count %0d: got %b want %b", k, ae[0], ae_tab[k]); end
      step();
    end
    vin[0] = 1'b0; ordy[0] = 1'b1;
    for (int k = 6; k >= 1; k--) begin
      @(negedge clk);
      n_checks++; if (cnt[0] !== 4'(k)) begin n_fail++; $display("FAIL wm_count: got %0d want %0d", cnt[0], k); end
      n_checks++; if (af[0] !== af_tab[k]) begin n_fail++; $display("FAIL wm_drain_af count %0d: got %b want %b", k, af[0], af_tab[k]); end
      n_checks++; if (ae[0] !== ae_tab[k]) begin n_fail++; $display("FAIL wm_drain_ae count %0d: got %b want %b", k, ae[0], ae_tab[k]); end
      n_checks++; if (dout[0] !== 16'h0100 + 16'(6 - k)) begin n_fail++; $display("FAIL wm_drain_data: got %h want %h", dout[0], 16'h0100 + 16'(6 - k)); end
      step();
    end
    ordy[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (ae[0] !== 1'b1) begin n_fail++; $display("FAIL wm_empty_ae: got %b want 1", ae[0]); end
    step();
  endtask

  task automatic test_back_to_back_full();
    logic [DW-1:0] want;
    ordy[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vin[0] = 1'b1; din[0] = 16'h0010 + 16'(i);
      step();
    end
    for (int c = 0; c < 4; c++) begin
      vin[0] = 1'b1; ordy[0] = 1'b1; din[0] = 16'h0020 + 16'(c);
      @(negedge clk);
      n_checks++; if (irdy[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready cycle %0d: got %b want 1", c, irdy[0]); end
      n_checks++; if (cnt[0] !== 4'd8) begin n_fail++; $display("FAIL b2b_count cycle %0d: got %0d want 8", c, cnt[0]); end
      n_checks++; if (dout[0] !== 16'h0010 + 16'(c)) begin n_fail++; $display("FAIL b2b_data cycle %0d: got %h want %h", c, dout[0], 16'h0010 + 16'(c)); end
      step();
    end
    vin[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      want = (i < 4) ? 16'h0014 + 16'(i) : 16'h0020 + 16'(i - 4);
      @(negedge clk);
      n_checks++; if (dout[0] !== want) begin n_fail++; $display("FAIL wrap_drain_data word %0d: got %h want %h", i, dout[0], want); end
      step();
    end
    ordy[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (cnt[0] !== 4'd0) begin n_fail++; $display("FAIL wrap_drained_count: got %0d want 0", cnt[0]); end
    n_checks++; if (vout[0] !== 1'b0) begin n_fail++; $display("FAIL wrap_drained_valid: got %b want 0", vout[0]); end
    step();
  endtask

  task automatic test_bypass();
    vin[1] = 1'b1; ordy[1] = 1'b1; din[1] = 16'hBEEF;
    @(negedge clk);
    n_checks++; if (vout[1] !== 1'b1) begin n_fail++; $display("FAIL bypass_valid: got %b want 1", vout[1]); end
    n_checks++; if (dout[1] !== 16'hBEEF) begin n_fail++; $display("FAIL bypass_data: got %h want beef", dout[1]); end
    n_checks++; if (irdy[1] !== 1'b1) begin n_fail++; $display("FAIL bypass_in_ready: got %b want 1", irdy[1]); end
    step();
    vin[1] = 1'b0;
    @(negedge clk);
    n_checks++; if (cnt[1] !== 4'd0) begin n_fail++; $display("FAIL bypass_count: got %0d want 0", cnt[1]); end
    n_checks++; if (vout[1] !== 1'b0) begin n_fail++; $display("FAIL bypass_after_valid: got %b want 0", vout[1]); end
    step();
    vin[1] = 1'b1; ordy[1] = 1'b0; din[1] = 16'hCAFE;
    @(negedge clk);
    n_checks++; if (dout[1] !== 16'hCAFE) begin n_fail++; $display("FAIL bypass_stall_data: got %h want cafe", dout[1]); end
    step();
    vin[1] = 1'b0; ordy[1] = 1'b1;
    @(negedge clk);
    n_checks++; if (cnt[1] !== 4'd1) begin n_fail++; $display("FAIL bypass_stored_count: got %0d want 1", cnt[1]); end
    n_checks++; if (dout[1] !== 16'hCAFE) begin n_fail++; $display("FAIL bypass_stored_data: got %h want cafe", dout[1]); end
    step();
    ordy[1] = 1'b0;
    @(negedge clk);
    n_checks++; if (cnt[1] !== 4'd0) begin n_fail++; $display("FAIL bypass_final_count: got %0d want 0", cnt[1]); end
    step();
  endtask

  task automatic test_flush();
    ordy[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vin[0] = 1'b1; din[0] = 16'h0040 + 16'(i);
      step();
    end
    flush[0] = 1'b1; vin[0] = 1'b1; ordy[0] = 1'b1; din[0] = 16'hAAAA;
    @(negedge clk);
    n_checks++; if (irdy[0] !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", irdy[0]); end
    n_checks++; if (vout[0] !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", vout[0]); end
    n_checks++; if (cnt[0] !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 5", cnt[0]); end
    step();
    flush[0] = 1'b0; vin[0] = 1'b0; ordy[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (cnt[0] !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", cnt[0]); end
    n_checks++; if (vout[0] !== 1'b0) begin n_fail++; $display("FAIL flush_after_valid: got %b want 0", vout[0]); end
    n_checks++; if (ae[0] !== 1'b1) begin n_fail++; $display("FAIL flush_almost_empty: got %b want 1", ae[0]); end
    step();
    vin[0] = 1'b1; din[0] = 16'h7777;
    step();
    vin[0] = 1'b0; ordy[0] = 1'b1;
    @(negedge clk);
    n_checks++; if (dout[0] !== 16'h7777) begin n_fail++; $display("FAIL post_flush_data: got %h want 7777", dout[0]); end
    n_checks++; if (cnt[0] !== 4'd1) begin n_fail++; $display("FAIL post_flush_count: got %0d want 1", cnt[0]); end
    step();
    ordy[0] = 1'b0;
    step();
  endtask

  task automatic test_random();
    int pushes = 0;
    int cycles = 0;
    int vduty, rduty;
    bit did_reset = 1'b0;
    bit pushed;
    logic [DW-1:0] want;
    vin[0] = 1'b0; ordy[0] = 1'b0;
    exp_q.delete();
    while (pushes < 500 && cycles < 20000) begin
      vduty = duty_tab[(pushes / 100) % 5];
      rduty = duty_tab[(pushes / 100 + 2) % 5];
      if (!vin[0] && $urandom_range(1, 100) <= vduty) begin
        vin[0] = 1'b1; din[0] = 16'($urandom);
      end
      ordy[0] = ($urandom_range(1, 100) <= rduty);
      if (!did_reset && pushes >= 250) srst[0] = 1'b1;
      @(negedge clk);
      n_checks++; if (cnt[0] !== 4'(exp_q.size())) begin n_fail++; $display("FAIL rand_count cycle %0d: got %0d want %0d", cycles, cnt[0], exp_q.size()); end
      if (vout[0] && ordy[0]) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_pop_empty cycle %0d: got data %h want no valid", cycles, dout[0]);
        end else begin
          want = exp_q.pop_front();
          if (dout[0] !== want) begin n_fail++; $display("FAIL rand_data cycle %0d: got %h want %h", cycles, dout[0], want); end
        end
      end
      pushed = vin[0] && irdy[0];
      if (pushed) begin
        exp_q.push_back(din[0]);
        pushes++;
      end
      step();
      if (pushed) vin[0] = 1'b0;
      if (srst[0]) begin
        srst[0] = 1'b0; did_reset = 1'b1;
        exp_q.delete();
      end
      cycles++;
    end
    n_checks++; if (pushes < 500) begin n_fail++; $display("FAIL rand_timeout: got %0d pushes want 500", pushes); end
    vin[0] = 1'b0; ordy[0] = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (vout[0]) begin
        want = exp_q.pop_front();
        n_checks++; if (dout[0] !== want) begin n_fail++; $display("FAIL rand_drain_data: got %h want %h", dout[0], want); end
      end
      step();
    end
    ordy[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (cnt[0] !== 4'd0) begin n_fail++; $display("FAIL rand_final_count: got %0d want 0", cnt[0]); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_leftover: got %0d words want 0", exp_q.size()); end
    step();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      srst[s] = 1'b1; flush[s] = 1'b0; vin[s] = 1'b0; ordy[s] = 1'b0; din[s] = '0;
    end
    test_reset(0);
    test_reset(1);
    test_fill_drain();
    test_latency();
    test_watermarks();
    test_back_to_back_full();
    test_bypass();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
